io_port: RTL and testbench

- Responder end of the MEM-stage IO interface.
- Accepts CPU writes, strobed by io_we with data_out, into an output FIFO that drains to an external device over a valid/ready handshake.
- Supplies data_in to the MEM stage from an input FIFO filled by an external device. The FIFO is show-ahead, so the head word is valid combinationally in the same cycle io_re is asserted.
- Sits beside data RAM, driven directly by the MEM stage outputs.

---
 rtl/io_port_if.sv | 38 +++
 rtl/io_port.sv | 93 +++++++++
 tb/tb_io_port.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/io_port_if.sv
// CPU-side strobes/data and external-device FIFO handshakes for io_port.
// Latency: wires only.
// Backpressure: ext_in_ready and ext_out_ready carry the device-side flow control.
interface io_port_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 2
);
  logic              io_we;
  logic              io_re;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] ext_in_data;
  logic              ext_in_valid;
  logic              ext_in_ready;
  logic [DATA_W-1:0] ext_out_data;
  logic              ext_out_valid;
  logic              ext_out_ready;
  logic [DATA_W-1:0] led_o;
  logic [AW:0]       in_count;
  logic [AW:0]       out_count;
  logic              ovf_o;
  logic              udf_o;
  logic              clr_flags;

  // CPU / external device side
  modport master (
    output io_we, io_re, data_out, ext_in_data, ext_in_valid, ext_out_ready, clr_flags,
    input  data_in, ext_in_ready, ext_out_data, ext_out_valid, led_o,
           in_count, out_count, ovf_o, udf_o
  );

  // io_port side
  modport slave (
    input  io_we, io_re, data_out, ext_in_data, ext_in_valid, ext_out_ready, clr_flags,
    output data_in, ext_in_ready, ext_out_data, ext_out_valid, led_o,
           in_count, out_count, ovf_o, udf_o
  );
endinterface

// File: rtl/io_port.sv
// MEM-stage IO responder: CPU writes go to an output FIFO, CPU reads come from a show-ahead input FIFO.
// Latency: CPU write to ext_out_valid 1 cycle; external push to data_in 1 cycle; data_in is combinational.
// Backpressure: ext_in_ready drops when the input FIFO is full; CPU writes into a full, undrained output FIFO are dropped and flagged.
module io_port #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int AW     = 2
) (
  input  logic       clk,
  input  logic       rst,
  io_port_if.slave   bus
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] in_mem_q  [DEPTH];
  logic [DATA_W-1:0] out_mem_q [DEPTH];
  logic [AW-1:0]     in_wr_q, in_rd_q, out_wr_q, out_rd_q;
  logic [AW:0]       in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [DATA_W-1:0] led_q;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              in_empty, in_full, out_empty, out_full;
  logic              ext_push, cpu_pop, drain, cpu_push;

  // Handshake decode, occupancy next-state and sticky flag next-state
  always_comb begin
    in_empty  = (in_cnt_q == '0);
    in_full   = (in_cnt_q == DEPTH_C);
    out_empty = (out_cnt_q == '0);
    out_full  = (out_cnt_q == DEPTH_C);
    // ready is forced low while reset is asserted so no word is taken then
    ext_push  = bus.ext_in_valid && rst && !in_full;
    cpu_pop   = bus.io_re && !in_empty;
    drain     = !out_empty && bus.ext_out_ready;
    // a same-cycle drain frees the slot a full FIFO needs
    cpu_push  = bus.io_we && (!out_full || drain);
    in_cnt_d  = in_cnt_q + (AW+1)'(ext_push) - (AW+1)'(cpu_pop);
    out_cnt_d = out_cnt_q + (AW+1)'(cpu_push) - (AW+1)'(drain);
    // a set event in the same cycle as clr_flags wins
    ovf_d = ovf_q;
    if (bus.clr_flags)                ovf_d = 1'b0;
    if (bus.io_we && !cpu_push)       ovf_d = 1'b1;
    udf_d = udf_q;
    if (bus.clr_flags)                udf_d = 1'b0;
    if (bus.io_re && in_empty)        udf_d = 1'b1;
  end

  // Pointers, counts, display latch and flags; storage itself is never reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_wr_q   <= '0;
      in_rd_q   <= '0;
      out_wr_q  <= '0;
      out_rd_q  <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      led_q     <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      if (ext_push) in_wr_q  <= in_wr_q + AW'(1);
      if (cpu_pop)  in_rd_q  <= in_rd_q + AW'(1);
      if (cpu_push) out_wr_q <= out_wr_q + AW'(1);
      if (drain)    out_rd_q <= out_rd_q + AW'(1);
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      if (bus.io_we) led_q <= bus.data_out;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  // Input FIFO storage write from the external device
  always_ff @(posedge clk) begin
    if (ext_push) in_mem_q[in_wr_q] <= bus.ext_in_data;
  end

  // Output FIFO storage write from the CPU
  always_ff @(posedge clk) begin
    if (cpu_push) out_mem_q[out_wr_q] <= bus.data_out;
  end

  assign bus.ext_in_ready  = rst && !in_full;
  assign bus.data_in       = in_empty  ? '0 : in_mem_q[in_rd_q];
  assign bus.ext_out_valid = !out_empty;
  assign bus.ext_out_data  = out_empty ? '0 : out_mem_q[out_rd_q];
  assign bus.led_o         = led_q;
  assign bus.in_count      = in_cnt_q;
  assign bus.out_count     = out_cnt_q;
  assign bus.ovf_o         = ovf_q;
  assign bus.udf_o         = udf_q;

endmodule

// File: tb/tb_io_port.sv
// Self-checking bench for io_port: per-cycle vector table with expected counts/flags/led,
// plus queue scoreboards for FIFO data and hand-written reset sequences.
module tb_io_port;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int AW     = 2;

  logic clk;
  logic rst;

  io_port_if #(.DATA_W(DATA_W), .AW(AW)) bus ();

  io_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] dout;
    logic [31:0] ed;
    logic        ev;
    logic        eor;
    logic        clr;
    int          oc;
    int          ic;
    logic        ovf;
    logic        udf;
    logic [31:0] led;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] in_q[$];
  logic [31:0] out_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic re, input logic [31:0] dout,
                              input logic [31:0] ed, input logic ev, input logic eor,
                              input logic clr, input int oc, input int ic,
                              input logic ovf, input logic udf, input logic [31:0] led);
    vec_t v;
    v.we = we; v.re = re; v.dout = dout; v.ed = ed; v.ev = ev; v.eor = eor; v.clr = clr;
    v.oc = oc; v.ic = ic; v.ovf = ovf; v.udf = udf; v.led = led;
    return v;
  endfunction

  // Called at posedge+1: drive, check before the edge against the scoreboard, then check after it.
  task automatic cyc(input vec_t v);
    logic rdy_m, vld_m, drain_m, acc_m, pop_m, push_m;
    bus.io_we = v.we; bus.io_re = v.re; bus.data_out = v.dout;
    bus.ext_in_data = v.ed; bus.ext_in_valid = v.ev;
    bus.ext_out_ready = v.eor; bus.clr_flags = v.clr;
    @(negedge clk);
    rdy_m = (in_q.size() != DEPTH);
    vld_m = (out_q.size() != 0);
    chk("ext_in_ready",  {31'b0, bus.ext_in_ready},  {31'b0, rdy_m});
    chk("ext_out_valid", {31'b0, bus.ext_out_valid}, {31'b0, vld_m});
    chk("ext_out_data",  bus.ext_out_data, vld_m ? out_q[0] : 32'h0);
    chk("data_in",       bus.data_in, (in_q.size() != 0) ? in_q[0] : 32'h0);
    drain_m = vld_m && v.eor;
    acc_m   = v.we && (out_q.size() != DEPTH || drain_m);
    pop_m   = v.re && (in_q.size() != 0);
    push_m  = v.ev && rdy_m;
    if (drain_m) void'(out_q.pop_front());
    if (acc_m)   out_q.push_back(v.dout);
    if (pop_m)   void'(in_q.pop_front());
    if (push_m)  in_q.push_back(v.ed);
    @(posedge clk);
    #1;
    chk("out_count", {29'b0, bus.out_count}, v.oc);
    chk("in_count",  {29'b0, bus.in_count},  v.ic);
    chk("ovf_o", {31'b0, bus.ovf_o}, {31'b0, v.ovf});
    chk("udf_o", {31'b0, bus.udf_o}, {31'b0, v.udf});
    chk("led_o", bus.led_o, v.led);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data_in"},       bus.data_in, 32'h0);
    chk({tag, "_ext_out_data"},  bus.ext_out_data, 32'h0);
    chk({tag, "_ext_out_valid"}, {31'b0, bus.ext_out_valid}, 32'h0);
    chk({tag, "_ext_in_ready"},  {31'b0, bus.ext_in_ready}, 32'h0);
    chk({tag, "_in_count"},      {29'b0, bus.in_count}, 32'h0);
    chk({tag, "_out_count"},     {29'b0, bus.out_count}, 32'h0);
    chk({tag, "_led_o"},         bus.led_o, 32'h0);
    chk({tag, "_ovf_o"},         {31'b0, bus.ovf_o}, 32'h0);
    chk({tag, "_udf_o"},         {31'b0, bus.udf_o}, 32'h0);
  endtask

  task automatic idle_inputs();
    bus.io_we = 0; bus.io_re = 0; bus.data_out = '0; bus.ext_in_data = '0;
    bus.ext_in_valid = 0; bus.ext_out_ready = 0; bus.clr_flags = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Rows: we, re, dout, ext_in_data, ext_in_valid, ext_out_ready, clr | out_cnt, in_cnt, ovf, udf, led
    // CPU write, hold, then drain
    tbl.push_back(mk(1,0,32'hA5,0,0,0,0, 1,0,0,0,32'hA5));
    tbl.push_back(mk(0,0,0,0,0,0,0,       1,0,0,0,32'hA5));
    tbl.push_back(mk(0,0,0,0,0,1,0,       0,0,0,0,32'hA5));
    // Overflow: five writes, no drain
    for (int i = 1; i <= 5; i++)
      tbl.push_back(mk(1,0,i,0,0,0,0, (i < 4) ? i : 4, 0, (i == 5), 0, i));
    // Drain 1..4, then clear the sticky overflow
    for (int i = 1; i <= 4; i++)
      tbl.push_back(mk(0,0,0,0,0,1,0, 4-i,0,1,0,32'h5));
    tbl.push_back(mk(0,0,0,0,0,0,1,       0,0,0,0,32'h5));
    // Fill again; fifth write lands because a drain happens in the same cycle
    for (int i = 1; i <= 4; i++)
      tbl.push_back(mk(1,0,i,0,0,0,0, i,0,0,0,i));
    tbl.push_back(mk(1,0,32'h5,0,0,1,0,   4,0,0,0,32'h5));
    for (int i = 1; i <= 4; i++)
      tbl.push_back(mk(0,0,0,0,0,1,0, 4-i,0,0,0,32'h5));
    // Input path: fill to full, push refused while full
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,0,0,32'h10+i,1,0,0, 0,i+1,0,0,32'h5));
    tbl.push_back(mk(0,0,0,32'h99,1,0,0,  0,4,0,0,32'h5));
    // Pops interleaved with pushes 0x14/0x15; read pointer wraps
    tbl.push_back(mk(0,1,0,0,0,0,0,       0,3,0,0,32'h5));
    tbl.push_back(mk(0,0,0,32'h14,1,0,0,  0,4,0,0,32'h5));
    tbl.push_back(mk(0,1,0,0,0,0,0,       0,3,0,0,32'h5));
    tbl.push_back(mk(0,1,0,32'h15,1,0,0,  0,3,0,0,32'h5));
    tbl.push_back(mk(0,1,0,0,0,0,0,       0,2,0,0,32'h5));
    tbl.push_back(mk(0,1,0,0,0,0,0,       0,1,0,0,32'h5));
    tbl.push_back(mk(0,1,0,0,0,0,0,       0,0,0,0,32'h5));
    // Underflow with same-cycle push: no bypass, word stored
    tbl.push_back(mk(0,1,0,32'h77,1,0,0,  0,1,0,1,32'h5));
    tbl.push_back(mk(0,0,0,0,0,0,0,       0,1,0,1,32'h5));
    tbl.push_back(mk(0,0,0,0,0,0,1,       0,1,0,0,32'h5));
    tbl.push_back(mk(0,1,0,0,0,0,1,       0,0,0,0,32'h5));
    // Underflow event beats a same-cycle clear
    tbl.push_back(mk(0,1,0,0,0,0,1,       0,0,0,1,32'h5));
    // Write and read together, serviced independently
    tbl.push_back(mk(1,1,32'hCC,0,0,0,0,  1,0,0,1,32'hCC));
    tbl.push_back(mk(0,0,0,0,0,1,0,       0,0,0,1,32'hCC));
    // Setup for async reset: out_count 2, in_count 3
    tbl.push_back(mk(1,0,32'h21,32'h31,1,0,0, 1,1,0,1,32'h21));
    tbl.push_back(mk(1,0,32'h22,32'h32,1,0,0, 2,2,0,1,32'h22));
    tbl.push_back(mk(0,0,0,32'h33,1,0,0,      2,3,0,1,32'h22));

    // Reset held for three cycles
    idle_inputs();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst_hold");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_ext_in_ready", {31'b0, bus.ext_in_ready}, 32'h1);
    chk("rel_in_count",  {29'b0, bus.in_count},  32'h0);
    chk("rel_out_count", {29'b0, bus.out_count}, 32'h0);

    foreach (tbl[i]) cyc(tbl[i]);

    // Asynchronous reset between clock edges
    idle_inputs();
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    in_q.delete();
    out_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ext_in_ready", {31'b0, bus.ext_in_ready}, 32'h1);
    // Fresh traffic after reset reuses the FIFOs cleanly
    cyc(mk(1,0,32'h55,32'h66,1,0,0, 1,1,0,0,32'h55));
    cyc(mk(0,1,0,0,0,1,0,           0,0,0,0,32'h55));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
